imm_gen_pipe: RTL and testbench

//  Registered, handshaked immediate-generation stage for the RV32I/RV64I decode path.

---
 rtl/rv_imm_pkg.sv | 29 ++
 rtl/imm_decode.sv | 74 +++++++
 rtl/imm_gen_pipe.sv | 81 ++++++++
 tb/tb_imm_gen_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg: format codes and RV32I/RV64I base opcodes for immediate generation
package rv_imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational instruction -> {immediate, format, illegal} decode
module imm_decode
    import rv_imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    logic            w_sign;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_i, w_s, w_b, w_u, w_j, w_z;

    assign w_sign = i_instr[31];
    assign w_opc  = i_instr[6:0];
    assign w_f3   = i_instr[14:12];
    assign w_i    = {{(XLEN-12){w_sign}}, i_instr[31:20]};
    assign w_s    = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
    assign w_b    = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_u    = {{(XLEN-31){w_sign}}, i_instr[30:12], 12'b0};
    assign w_j    = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_z    = {{(XLEN-5){1'b0}}, i_instr[19:15]};

    // Select the immediate layout by opcode; RV64-only opcodes are illegal on RV32
    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: begin
                o_imm = w_i;
                o_fmt = FMT_I;
            end
            OPC_OPIMM32: begin
                o_imm     = (XLEN == 64) ? w_i : '0;
                o_fmt     = (XLEN == 64) ? FMT_I : FMT_NONE;
                o_illegal = (XLEN != 64);
            end
            OPC_STORE: begin
                o_imm = w_s;
                o_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                o_imm = w_b;
                o_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_imm = w_u;
                o_fmt = FMT_U;
            end
            OPC_JAL: begin
                o_imm = w_j;
                o_fmt = FMT_J;
            end
            OPC_OP: o_fmt = FMT_R;
            OPC_OP32: begin
                o_fmt     = (XLEN == 64) ? FMT_R : FMT_NONE;
                o_illegal = (XLEN != 64);
            end
            OPC_SYSTEM: begin
                o_imm     = (w_f3[2] && EN_ZICSR) ? w_z : '0;
                o_fmt     = (w_f3[2] && EN_ZICSR) ? FMT_Z : FMT_NONE;
                o_illegal = w_f3[2] && !EN_ZICSR;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decoded-immediate stage behind a 2-entry skid buffer with registered ready
module imm_gen_pipe
    import rv_imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  w_imm;
    fmt_e             w_fmt;
    logic             w_ill;
    logic             w_push, w_pop, w_last;
    logic [XLEN-1:0]  r_imm [2];
    fmt_e             r_fmt [2];
    logic             r_ill [2];
    logic [TAG_W-1:0] r_tag [2];
    logic             r_wr, r_rd;
    logic [1:0]       r_count;

    imm_decode #(.XLEN(XLEN), .EN_ZICSR(EN_ZICSR)) u_dec (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_ill)
    );

    assign in_ready    = ~r_count[1];
    assign out_valid   = (r_count != 2'd0);
    assign out_imm     = r_imm[r_rd];
    assign out_fmt     = r_fmt[r_rd];
    assign out_illegal = r_ill[r_rd];
    assign out_tag     = r_tag[r_rd];
    assign w_push      = in_valid & in_ready & ~flush;
    assign w_pop       = out_valid & out_ready;
    // Popping the only entry leaves r_rd on it so the payload holds while empty
    assign w_last      = w_pop & ~w_push & (r_count == 2'd1);

    // Buffer storage, pointers and occupancy; flush re-aligns the write pointer to the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_fmt[i] <= FMT_NONE;
                r_ill[i] <= 1'b0;
                r_tag[i] <= '0;
            end
            r_count <= 2'd0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else if (flush) begin
            r_count <= 2'd0;
            r_wr    <= r_rd;
        end else begin
            if (w_push) begin
                r_imm[r_wr] <= w_imm;
                r_fmt[r_wr] <= w_fmt;
                r_ill[r_wr] <= w_ill;
                r_tag[r_wr] <= in_tag;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_rd    <= (w_pop & ~w_last) ? ~r_rd : r_rd;
            r_wr    <= w_last ? r_rd : (w_push ? ~r_wr : r_wr);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table plus scoreboard for imm_gen_pipe (RV32 and RV64 builds)
module tb_imm_gen_pipe;
    import rv_imm_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    fmt_e        out_fmt;
    logic        out_illegal;
    logic [31:0] out_tag;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_instr64 = '0;
    logic        out_valid64;
    logic [63:0] out_imm64;
    fmt_e        out_fmt64;
    logic        out_illegal64;
    logic [7:0]  out_tag64;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t nxt = '0;
    vec_t vt[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .EN_ZICSR(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .EN_ZICSR(1'b0)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instr(in_instr64), .in_tag(8'h5A), .out_valid(out_valid64), .out_ready(1'b1),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: record accepts, compare every pop in FIFO order
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_pop_tag", {32'h0, out_tag}, 64'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("sb_imm", {32'h0, out_imm}, {32'h0, e.imm});
                    chk("sb_fmt", {61'h0, out_fmt}, {61'h0, e.fmt});
                    chk("sb_ill", {63'h0, out_illegal}, {63'h0, e.ill});
                    chk("sb_tag", {32'h0, out_tag}, {32'h0, e.tag});
                end
            end
            if (in_valid && in_ready) q.push_back(nxt);
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] tg,
                        input logic [31:0] eimm, input logic [2:0] ef, input logic eill);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tg;
        nxt      = '{eimm, ef, eill, tg};
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'h0, 64'h1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue", 64'(q.size()), 64'h0);
        chk("drain_valid", {63'h0, out_valid}, 64'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic t64(input logic [31:0] ins, input logic [63:0] eimm, input logic [2:0] ef, input logic eill);
        in_valid64 = 1'b1;
        in_instr64 = ins;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        @(negedge clk);
        chk("x64_valid", {63'h0, out_valid64}, 64'h1);
        chk("x64_imm", out_imm64, eimm);
        chk("x64_fmt", {61'h0, out_fmt64}, {61'h0, ef});
        chk("x64_ill", {63'h0, out_illegal64}, {63'h0, eill});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt.push_back('{32'hFFF00003, 32'hFFFFFFFF, FMT_I, 1'b0});
        vt.push_back('{32'hFE000023, 32'hFFFFFFE0, FMT_S, 1'b0});
        vt.push_back('{32'hFE000FE3, 32'hFFFFFFFE, FMT_B, 1'b0});
        vt.push_back('{32'h12345037, 32'h12345000, FMT_U, 1'b0});
        vt.push_back('{32'h0080006F, 32'h00000008, FMT_J, 1'b0});
        vt.push_back('{32'h0000007F, 32'h00000000, FMT_NONE, 1'b1});
        vt.push_back('{32'h0007D073, 32'h0000000F, FMT_Z, 1'b0});
        vt.push_back('{32'h80010093, 32'hFFFFF800, FMT_I, 1'b0});
        vt.push_back('{32'h00008067, 32'h00000000, FMT_I, 1'b0});
        vt.push_back('{32'h0FF0000F, 32'h000000FF, FMT_I, 1'b0});
        vt.push_back('{32'h00B50533, 32'h00000000, FMT_R, 1'b0});
        vt.push_back('{32'h00000073, 32'h00000000, FMT_NONE, 1'b0});
        vt.push_back('{32'h0010001B, 32'h00000000, FMT_NONE, 1'b1});
        vt.push_back('{32'h0000003B, 32'h00000000, FMT_NONE, 1'b1});
        vt.push_back('{32'hFFFFF017, 32'hFFFFF000, FMT_U, 1'b0});
        vt.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, FMT_J, 1'b0});
        vt.push_back('{32'h00509093, 32'h00000005, FMT_I, 1'b0});
        vt.push_back('{32'h4050D093, 32'h00000405, FMT_I, 1'b0});

        #12;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_out_imm", {32'h0, out_imm}, 64'h0);
        chk("rst_out_fmt", {61'h0, out_fmt}, 64'h7);
        chk("rst_out_ill", {63'h0, out_illegal}, 64'h0);
        chk("rst_out_tag", {32'h0, out_tag}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accept at one edge, valid by the next
        out_ready = 1'b0;
        send(32'hFFF00003, 32'h77, 32'hFFFFFFFF, FMT_I, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", {63'h0, out_valid}, 64'h1);
        chk("lat_imm", {32'h0, out_imm}, 64'hFFFFFFFF);
        @(posedge clk);
        #1;
        drain();

        // Vector table streamed back to back
        out_ready = 1'b1;
        foreach (vt[i]) send(vt[i].instr, 32'(i + 100), vt[i].imm, vt[i].fmt, vt[i].ill);
        drain();

        // Backpressure: fills after two accepts, drains in order
        out_ready = 1'b0;
        send(32'h00100093, 32'd1, 32'd1, FMT_I, 1'b0);
        send(32'h00200093, 32'd2, 32'd2, FMT_I, 1'b0);
        in_instr = 32'h00300093;
        in_tag   = 32'd3;
        nxt      = '{32'd3, FMT_I, 1'b0, 32'd3};
        @(negedge clk);
        chk("full_in_ready", {63'h0, in_ready}, 64'h0);
        chk("full_out_valid", {63'h0, out_valid}, 64'h1);
        chk("full_head_tag", {32'h0, out_tag}, 64'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00300093, 32'd3, 32'd3, FMT_I, 1'b0);
        drain();

        // Flush with two held entries and a simultaneous push
        out_ready = 1'b0;
        send(32'h01000093, 32'h10, 32'h10, FMT_I, 1'b0);
        send(32'h01100093, 32'h11, 32'h11, FMT_I, 1'b0);
        in_instr = 32'h0DE00093;
        in_tag   = 32'hDEAD;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
        chk("flush_hold_tag", {32'h0, out_tag}, 64'h10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_stays_empty", {63'h0, out_valid}, 64'h0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'hFFF00003, 32'h20, 32'hFFFFFFFF, FMT_I, 1'b0);
        send(32'hFE000023, 32'h21, 32'hFFFFFFE0, FMT_S, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("arst_out_imm", {32'h0, out_imm}, 64'h0);
        chk("arst_out_fmt", {61'h0, out_fmt}, 64'h7);
        chk("arst_out_tag", {32'h0, out_tag}, 64'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h12345037, 32'h30, 32'h12345000, FMT_U, 1'b0);
        drain();

        // RV64 build without Zicsr
        t64(32'hFFF0001B, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
        chk("x64_tag", {56'h0, out_tag64}, 64'h5A);
        t64(32'h80000037, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
        t64(32'h0000003B, 64'h0, FMT_R, 1'b0);
        t64(32'h0007D073, 64'h0, FMT_NONE, 1'b1);
        t64(32'h00000073, 64'h0, FMT_NONE, 1'b0);
        t64(32'h7FF03003, 64'h7FF, FMT_I, 1'b0);
        chk("x64_in_ready", {63'h0, in_ready64}, 64'h1);

        chk("final_queue", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
